pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central pipeline sequencer for the MIPS core, parametrised in stage count.
- Owns run/step/halt sequencing requested by the debug unit (DU).
- Turns hazard-unit stall requests, ID-stage branch/jump redirects and halt-opcode detection into per-register enables and flushes, plus the PC write enable.
- Tracks which pipeline registers hold valid instructions and reports when the pipeline is fully drained.

Parameters:
- NB_STAGES, 5, number of pipeline stages; NB_STAGES-1 inter-stage registers, index 0 = IF/ID. Legal range 3..8.
- NB_CNT, 32, width of the cycle counter and the optional performance counters.

Ports:
- clk  input  1  core clock.
- i_rst  input  1  synchronous reset, active-high.
- i_du_run  input  1  pulse; start free-running execution.
- i_du_step  input  1  pulse; advance exactly one cycle.
- i_du_halt  input  1  pulse; abort fetch and drain.
- i_load_use  input  1  load-use stall request from the hazard detection unit.
- i_branch_taken  input  1  taken branch/jump resolved in ID.
- i_halt_instr  input  1  halt opcode decoded in ID.
- o_pc_we  output  1  PC register write enable.
- o_stage_en  output  NB_STAGES-1  per-register load enable.
- o_stage_flush  output  NB_STAGES-1  per-register bubble insert.
- o_valid  output  NB_STAGES-1  occupancy of each register.
- o_state  output  3  current FSM state code.
- o_halted  output  1  high in HALTED.
- o_cycle_cnt  output  NB_CNT  advance cycles since reset.
- o_stall_cnt  output  NB_CNT  load-use stall cycles (optional feature).
- o_flush_cnt  output  NB_CNT  branch flush cycles (optional feature).

Behaviour:
- Reset (i_rst high at a clk edge):
  - state=IDLE, drain counter=0.
  - o_valid=0, all counters=0.
  - All combinational outputs follow from IDLE: o_pc_we=0, o_stage_en=0, o_stage_flush=0, o_halted=0.
  - Reset mid-run or mid-drain behaves identically; no instruction survives.
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- Transitions:
  - IDLE: i_du_halt -> DRAIN; else i_du_run -> RUN; else i_du_step -> STEP. Priority is halt > run > step.
  - RUN: (i_halt_instr & ~i_load_use) | i_du_halt -> DRAIN.
  - STEP: lasts exactly one cycle. Same DRAIN condition as RUN; otherwise -> IDLE.
  - DRAIN: on entry, drain counter loads NB_STAGES-2. It decrements each cycle; at 0 -> HALTED.
  - HALTED: sticky until reset. DU commands are ignored.
- adv = state in {RUN, STEP, DRAIN}. When adv=0, all enables, flushes and o_pc_we are 0 (pipeline frozen).
- RUN/STEP, no hazard: o_pc_we=1, all en=1, all flush=0.
- RUN/STEP with i_load_use:
  - o_pc_we=0, en[0]=0 (IF/ID holds).
  - flush[1]=1 (bubble into ID/EX); remaining en=1.
  - i_branch_taken and i_halt_instr are ignored that cycle; the stalled instruction re-presents them.
- RUN/STEP with i_branch_taken & ~i_load_use: o_pc_we=1, flush[0]=1.
- Transition cycle into DRAIN: o_pc_we=0, flush[0]=1, all en=1.
- DRAIN cycles: o_pc_we=0, en=1, flush[0]=1. i_load_use and i_branch_taken are ignored.
- Flush dominates enable: a register with flush[k]=1 loads a bubble on that edge.
- Valid tracking, on each edge:
  - valid[k] <= flush[k] ? 0 : (en[k] ? src : valid[k]).
  - src for k=0 is o_pc_we; for k>0 it is valid[k-1].
- o_cycle_cnt increments on every adv cycle and wraps at 2^NB_CNT.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - o_stall_cnt increments on each RUN/STEP cycle with i_load_use.
  - o_flush_cnt increments on each cycle where a branch flush asserts flush[0].
  - Both wrap and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Package pipeline_pkg holds:
  - state encodings (IDLE..HALTED);
  - register index constants IDX_IFID=0, IDX_IDEX=1, IDX_EXMEM=2, IDX_MEMWB=3;
  - default NB_STAGES/NB_CNT.
- One sub-module, pipe_valid_tracker: the valid shift register with hold/flush, parametrised by NB_STAGES.

Test Plan:
- Reset, then i_du_run pulse at cycle 2 -> state=1 at cycle 3, o_pc_we=1, o_stage_en=4'b1111, o_valid fills to 4'b1111 by cycle 7.
- RUN, i_load_use high 1 cycle -> o_pc_we=0, o_stage_en=4'b1110, o_stage_flush=4'b0010, valid[1]=0 next cycle.
- RUN, i_branch_taken & i_load_use together -> stall response only, no flush[0]; branch alone next cycle -> flush=4'b0001, pc_we=1.
- RUN, i_halt_instr -> DRAIN with counter=3, pc_we=0; o_halted=1 exactly 3 cycles later; o_valid=0 by then.
- IDLE, three i_du_step pulses -> o_cycle_cnt=3, state returns to IDLE after each, valid advances one register per pulse.
- Assert i_rst during DRAIN -> next cycle state=0, o_valid=0, o_cycle_cnt=0, o_halted=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline sequencer:
//   - pipe_state_t   : FSM state encodings (IDLE=0 .. HALTED=4)
//   - IDX_*          : inter-stage register indices (0 = IF/ID)
//   - DEF_NB_STAGES  : default pipeline depth
//   - DEF_NB_CNT     : default counter width
// ----------------------------------------------------------------------------
package pipeline_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } pipe_state_t;

   localparam int IDX_IFID  = 0;
   localparam int IDX_IDEX  = 1;
   localparam int IDX_EXMEM = 2;
   localparam int IDX_MEMWB = 3;

   localparam int DEF_NB_STAGES = 5;
   localparam int DEF_NB_CNT    = 32;

endpackage : pipeline_pkg

// File: rtl/pipe_valid_tracker.sv
// ----------------------------------------------------------------------------
// pipe_valid_tracker
// Occupancy shift register for the NB_STAGES-1 inter-stage registers.
// Each bit follows its pipeline register: flush loads a bubble, enable
// loads the upstream occupancy, otherwise the bit holds.
// Ports:
//   clk    : core clock
//   srst   : synchronous active-high reset (clears all occupancy)
//   pc_we  : PC write enable; a new fetch enters IF/ID when it is high
//   en     : per-register load enable
//   flush  : per-register bubble insert (dominates en)
//   valid  : per-register occupancy
// ----------------------------------------------------------------------------
module pipe_valid_tracker
   import pipeline_pkg::*;
#(
   parameter int NB_STAGES = DEF_NB_STAGES
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 pc_we,
   input  logic [NB_STAGES-2:0] en,
   input  logic [NB_STAGES-2:0] flush,
   output logic [NB_STAGES-2:0] valid
);

   localparam int NR = NB_STAGES - 1;

   logic [NR-1:0] valid_reg;
   logic [NR-1:0] src;

   // IF/ID is fed by the fetch stage: it holds a real instruction only
   // when the PC actually advanced.
   assign src[IDX_IFID] = pc_we;

   genvar gi;
   generate
      for (gi = 1; gi < NR; gi++) begin : g_src
         assign src[gi] = valid_reg[gi-1];
      end

      for (gi = 0; gi < NR; gi++) begin : g_bit
         always_ff @(posedge clk) begin
            if (srst) begin
               valid_reg[gi] <= 1'b0;
            end else if (flush[gi]) begin
               valid_reg[gi] <= 1'b0;
            end else if (en[gi]) begin
               valid_reg[gi] <= src[gi];
            end
         end
      end
   endgenerate

   assign valid = valid_reg;

endmodule : pipe_valid_tracker

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Central pipeline sequencer. Owns run/step/halt sequencing from the debug
// unit and converts load-use stalls, ID-stage redirects and halt-opcode
// detection into per-register enables/flushes and the PC write enable.
// Optional build macro: PIPE_PERF_CNT_EN adds stall/flush performance
// counters; without it o_stall_cnt/o_flush_cnt are tied to zero.
// Ports:
//   clk, i_rst         : clock, synchronous active-high reset
//   i_du_run/step/halt : debug-unit command pulses (halt > run > step)
//   i_load_use         : hazard-unit stall request
//   i_branch_taken     : taken branch/jump resolved in ID
//   i_halt_instr       : halt opcode decoded in ID
//   o_pc_we            : PC write enable
//   o_stage_en         : per-register load enable (index 0 = IF/ID)
//   o_stage_flush      : per-register bubble insert
//   o_valid            : per-register occupancy
//   o_state, o_halted  : FSM state code, high in HALTED
//   o_cycle_cnt        : advance cycles since reset
//   o_stall_cnt        : load-use stall cycles (optional)
//   o_flush_cnt        : branch flush cycles (optional)
// ----------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int NB_STAGES = DEF_NB_STAGES,
   parameter int NB_CNT    = DEF_NB_CNT
) (
   input  logic                 clk,
   input  logic                 i_rst,
   input  logic                 i_du_run,
   input  logic                 i_du_step,
   input  logic                 i_du_halt,
   input  logic                 i_load_use,
   input  logic                 i_branch_taken,
   input  logic                 i_halt_instr,
   output logic                 o_pc_we,
   output logic [NB_STAGES-2:0] o_stage_en,
   output logic [NB_STAGES-2:0] o_stage_flush,
   output logic [NB_STAGES-2:0] o_valid,
   output logic [2:0]           o_state,
   output logic                 o_halted,
   output logic [NB_CNT-1:0]    o_cycle_cnt,
   output logic [NB_CNT-1:0]    o_stall_cnt,
   output logic [NB_CNT-1:0]    o_flush_cnt
);

   localparam int NR = NB_STAGES - 1;
   localparam int DW = $clog2(NB_STAGES);
   // One drain cycle per register behind IF/ID; IF/ID itself is emptied
   // by the flush on the cycle that enters DRAIN.
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(NB_STAGES - 2);

   pipe_state_t       state_reg;
   logic [DW-1:0]     drain_cnt_reg;
   logic              halted_reg;
   logic [NB_CNT-1:0] cycle_cnt_reg;

   logic              adv;
   logic              run_like;
   logic              to_drain;
   logic              pc_we;
   logic [NR-1:0]     stage_en;
   logic [NR-1:0]     stage_flush;

   // ------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------
   always_comb begin
      run_like    = (state_reg == ST_RUN) || (state_reg == ST_STEP);
      adv         = run_like || (state_reg == ST_DRAIN);
      // A halt opcode sitting behind a load-use stall is not acted on yet;
      // it re-presents once the stall clears.
      to_drain    = run_like && (i_du_halt || (i_halt_instr && !i_load_use));
      pc_we       = 1'b0;
      stage_en    = '0;
      stage_flush = '0;

      if ((state_reg == ST_DRAIN) || to_drain) begin
         // Stop fetching, keep pushing everything downstream.
         stage_en              = '1;
         stage_flush[IDX_IFID] = 1'b1;
      end else if (run_like) begin
         stage_en = '1;
         if (i_load_use) begin
            stage_en[IDX_IFID]    = 1'b0;
            stage_flush[IDX_IDEX] = 1'b1;
         end else begin
            pc_we = 1'b1;
            if (i_branch_taken) begin
               stage_flush[IDX_IFID] = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Sequencer FSM and cycle counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_reg     <= ST_IDLE;
         drain_cnt_reg <= '0;
         halted_reg    <= 1'b0;
         cycle_cnt_reg <= '0;
      end else begin
         if (adv) begin
            cycle_cnt_reg <= cycle_cnt_reg + NB_CNT'(1);
         end
         unique case (state_reg)
            ST_IDLE: begin
               if (i_du_halt) begin
                  state_reg     <= ST_DRAIN;
                  drain_cnt_reg <= DRAIN_LOAD;
               end else if (i_du_run) begin
                  state_reg <= ST_RUN;
               end else if (i_du_step) begin
                  state_reg <= ST_STEP;
               end
            end
            ST_RUN: begin
               if (to_drain) begin
                  state_reg     <= ST_DRAIN;
                  drain_cnt_reg <= DRAIN_LOAD;
               end
            end
            ST_STEP: begin
               if (to_drain) begin
                  state_reg     <= ST_DRAIN;
                  drain_cnt_reg <= DRAIN_LOAD;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               // Leave once this cycle's decrement reaches zero.
               if (drain_cnt_reg <= DW'(1)) begin
                  state_reg     <= ST_HALTED;
                  halted_reg    <= 1'b1;
                  drain_cnt_reg <= '0;
               end else begin
                  drain_cnt_reg <= drain_cnt_reg - DW'(1);
               end
            end
            ST_HALTED: begin
               state_reg <= ST_HALTED;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Valid tracking
   // ------------------------------------------------------------------
   pipe_valid_tracker #(
      .NB_STAGES (NB_STAGES)
   ) u_valid (
      .clk   (clk),
      .srst  (i_rst),
      .pc_we (pc_we),
      .en    (stage_en),
      .flush (stage_flush),
      .valid (o_valid)
   );

   // ------------------------------------------------------------------
   // Optional performance counters
   // ------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
   logic [NB_CNT-1:0] stall_cnt_reg;
   logic [NB_CNT-1:0] flush_cnt_reg;
   logic              stall_inc;
   logic              flush_inc;

   assign stall_inc = run_like & i_load_use;
   // Only redirect flushes count, not the IF/ID flush used while draining.
   assign flush_inc = run_like & ~to_drain & ~i_load_use & i_branch_taken;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (stall_inc) begin
            stall_cnt_reg <= stall_cnt_reg + NB_CNT'(1);
         end
         if (flush_inc) begin
            flush_cnt_reg <= flush_cnt_reg + NB_CNT'(1);
         end
      end
   end

   assign o_stall_cnt = stall_cnt_reg;
   assign o_flush_cnt = flush_cnt_reg;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

   assign o_pc_we       = pc_we;
   assign o_stage_en    = stage_en;
   assign o_stage_flush = stage_flush;
   assign o_state       = state_reg;
   assign o_halted      = halted_reg;
   assign o_cycle_cnt   = cycle_cnt_reg;

endmodule : pipeline_ctrl
